// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the default bit period
// used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_CLK_PER_BIT = 400;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx (master) and its consumer (slave).
// The perr pulse exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] rdata;
  logic                   rx_valid;
  logic                   rx_ack;
  logic                   ferr;
  logic                   overrun;
`ifdef UART_RX_PARITY_EN
  logic                   perr;
`endif

`ifdef UART_RX_PARITY_EN
  modport master (output rdata, rx_valid, ferr, overrun, perr, input rx_ack);
  modport slave  (input rdata, rx_valid, ferr, overrun, perr, output rx_ack);
`else
  modport master (output rdata, rx_valid, ferr, overrun, input rx_ack);
  modport slave  (input rdata, rx_valid, ferr, overrun, output rx_ack);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL
// so an idle-high line does not look like a falling edge after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments keep the two stages as distinct flops; blocking would collapse them.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ack output register, framing and overrun pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the perr pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master rx_if
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

  logic                   rxd_sync;
  logic                   rxs_q;
  uart_state_e            state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [UART_DATA_W-1:0] rdata_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
  logic                   perr_q;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxd_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      // Extra retiming stage: rxs falls at T0+2, so START is entered at T0+3.
      rxs_q     <= rxd_sync;
      // NOTE: pulses default low each cycle; a later assignment in this block wins for one cycle.
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      if (rx_if.rx_ack && valid_q) valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxs_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rxs_q, shift_q[UART_DATA_W-1:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            par_q   <= rxs_q;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (!rxs_q) begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end else begin
              state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^shift_q) != par_q) begin
                perr_q <= 1'b1;
              end else
`endif
              if (!valid_q || rx_if.rx_ack) begin
                rdata_q <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rxs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.rdata    = rdata_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.ferr     = ferr_q;
  assign rx_if.overrun  = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.perr     = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver feeding bytes from the host link into `f_core`; the receive-side counterpart of `uart_tx` at the same bit rate. Oversamples `rxd` on the core clock and recovers 8N1 frames, LSB first. Holds each byte in a one-entry output register with a valid/ack handshake and flags framing and overrun errors.

## Interface
- `CLK_PER_BIT`, 400, core clocks per UART bit. Must be ≥ 4 and equal to the `uart_tx` setting.
- `clk`  in  1  core clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial line; idles high.
- `rdata`  out  8  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until acknowledged.
- `rx_ack`  in  1  consumer took `rdata`; ignored when `rx_valid`=0.
- `ferr`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because `rx_valid` was still 1.
- `perr`  out  1  one-cycle parity error pulse; only present with `UART_RX_PARITY_EN`.

## Operation
- Reset values:
  - `rdata`=0, `rx_valid`=0, `ferr`=0, `overrun`=0, `perr`=0.
  - Synchronizer flops = 1.
  - State = IDLE.
- `rxd` passes through a 2-flop synchronizer. All logic below uses the synchronized value `rxs`.
- Bit counter `cnt` is `$clog2(CLK_PER_BIT)` bits wide. Bit index is 3 bits.
- States:
  - IDLE: on `rxs`=0, clear `cnt` and go to START.
  - START: when `cnt` reaches `CLK_PER_BIT/2 - 1`, resample `rxs`.
    - `rxs`=1: glitch; return to IDLE with no error.
    - `rxs`=0: clear `cnt`, go to DATA.
  - DATA: every `CLK_PER_BIT` cycles, shift `rxs` into the MSB of the shift register (LSB first). After bit 7, go to STOP (or PARITY).
  - STOP: sample after `CLK_PER_BIT` cycles.
    - `rxs`=1: deliver the byte, go to IDLE.
    - `rxs`=0: pulse `ferr`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A held-low line produces exactly one `ferr`.
- Delivery, in the same cycle as the stop sample:
  - If `rx_valid`=0, or `rx_ack`=1 in that cycle: load `rdata`, set `rx_valid`=1.
  - Otherwise: keep the old `rdata` and `rx_valid`, pulse `overrun`, drop the new byte.
- `rx_ack` with `rx_valid`=1 and no delivery that cycle: `rx_valid`←0 on the next edge.
- `rst` asserted mid-frame: abort immediately and return to IDLE with reset values. A partial frame is never delivered.

## Timing
- Let T0 be the first edge at which the synchronizer input flop captures `rxd`=0.
- `rxs` falls at T0+2. START is entered at T0+3.
- Start bit is sampled at about half a bit. Each data and stop bit is sampled mid-bit, one `CLK_PER_BIT` period apart.
- `rx_valid` rises at T0 + 3 + `CLK_PER_BIT/2` + 9×`CLK_PER_BIT`. Add `CLK_PER_BIT` with parity.
- `ferr`, `overrun` and `perr` are high for exactly one cycle, coincident with the stop-sample edge.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. IDLE is re-entered at mid-stop, so no frame is missed.
- Consumer latency: `rx_ack` sampled high at edge N clears `rx_valid` at edge N. No combinational path from `rx_ack` to outputs.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds state PARITY between DATA and STOP. One bit period; expects even parity over the 8 data bits.
  - On mismatch, pulse `perr` at the stop-sample edge and discard the byte. `ferr` takes priority if both fail.
  - Port `perr` exists.
- Not defined: no PARITY state and no `perr` port. Frame is 8N1.

## Structure
- Shared package `uart_pkg`:
  - State enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `BREAK`).
  - `UART_DATA_W`=8.
  - Default `CLK_PER_BIT`=400, also used by `uart_tx`.
- One sub-module, `uart_sync2`: the 2-flop synchronizer with reset value 1, reusable for other async inputs.

## Test plan
Bench runs with `CLK_PER_BIT`=16, `rxd` driven by a bench model of `uart_tx`.
- Frame 0x55, `rx_ack` tied 1 → `rx_valid` pulses once at T0+3+8+144, with `rdata`=0x55, `ferr`=0, `overrun`=0.
- Frames 0xA3 then 0x0F back-to-back, `rx_ack` held 0 → `rdata`=0xA3 stays valid; `overrun` pulses once at the second stop sample; `rdata` is still 0xA3.
- 3-cycle low glitch on idle `rxd` → stays in IDLE; `rx_valid`, `ferr` and `overrun` stay 0.
- Frame 0x81 with stop bit forced 0, then line held low 50 cycles, then frame 0x3C → one `ferr` pulse, no byte for 0x81, then `rdata`=0x3C with `rx_valid`=1.
- `rst` pulsed during bit 4 of frame 0xFF, then frame 0x12 → no delivery of 0xFF; next `rdata`=0x12.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `perr` pulse, no `rx_valid`; 0x07 with parity bit 1 → `rdata`=0x07.
